// File: rtl/switch_input_port.sv
// Debounced, handshaked button + switch-bank input port: each debounced press captures Switches once.
// Optional sticky overrun flag is compiled in with `define SWITCH_INPUT_OVERRUN_EN.
module switch_input_port #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              Clock,
  input  logic              n_reset,
  input  logic              Button,
  input  logic [DATA_W-1:0] Switches,
  input  logic              data_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              pressed,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FULL, WAIT_REL} state_t;

  logic [1:0]        sync_reg;
  logic              sync_n;
  logic              stable_n_reg, stable_n_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              press_evt;
  logic              consume;
  state_t            state_reg, state_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset) sync_reg <= 2'b11;
    else          sync_reg <= {sync_reg[0], Button};
  end

  assign sync_n = sync_reg[1];

  always_comb begin
    stable_n_next = stable_n_reg;
    cnt_next      = '0;
    press_evt     = 1'b0;
    if (sync_n != stable_n_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_n_next = sync_n;
        press_evt     = stable_n_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset) begin
      stable_n_reg <= 1'b1;
      cnt_reg      <= '0;
    end else begin
      stable_n_reg <= stable_n_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign pressed    = ~stable_n_reg;
  assign data_valid = (state_reg == FULL);
  assign consume    = data_valid && data_ready;
  assign data_out   = data_out_reg;

  always_comb begin
    state_next    = state_reg;
    data_out_next = data_out_reg;
    case (state_reg)
      IDLE: begin
        if (press_evt) begin
          data_out_next = Switches;
          state_next    = FULL;
        end
      end
      FULL: begin
        // A press coinciding with the consume is dropped; the button is then held, so wait for release.
        if (consume) begin
          if (press_evt || !stable_n_reg) state_next = WAIT_REL;
          else                            state_next = IDLE;
        end
      end
      WAIT_REL: begin
        if (stable_n_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= IDLE;
      data_out_reg <= '0;
    end else begin
      state_reg    <= state_next;
      data_out_reg <= data_out_next;
    end
  end

`ifdef SWITCH_INPUT_OVERRUN_EN
  logic overrun_reg;

  // Set has priority over the clearing handshake in the same cycle.
  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset)                           overrun_reg <= 1'b0;
    else if (state_reg == FULL && press_evt) overrun_reg <= 1'b1;
    else if (consume)                        overrun_reg <= 1'b0;
  end

  assign overrun = overrun_reg;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port (DEBOUNCE_CYCLES=4): directed scenarios plus a randomized
// run compared against a behavioural model of the port.
module tb_switch_input_port;

  localparam int DEB = 4;
`ifdef SWITCH_INPUT_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        button = 1'b1;
  logic [15:0] sw = '0;
  logic        ready = 1'b0;
  logic        dv;
  logic [15:0] dout;
  logic        prs;
  logic        ovr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_input_port #(.DATA_W(16), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .Clock(clk), .n_reset(rst_n), .Button(button), .Switches(sw), .data_ready(ready),
    .data_valid(dv), .data_out(dout), .pressed(prs), .overrun(ovr)
  );

  // Behavioural model: button history, run length of disagreement, and a pending-word record.
  logic        m_s1 = 1'b1, m_sync = 1'b1, m_stable_n = 1'b1;
  int          m_run = 0;
  logic        m_pend = 1'b0, m_wait = 1'b0, m_ovr = 1'b0;
  logic [15:0] m_word = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1'b1; m_sync = 1'b1; m_stable_n = 1'b1; m_run = 0;
      m_pend = 1'b0; m_wait = 1'b0; m_ovr = 1'b0; m_word = '0;
    end else begin
      logic flip, press, was_pressed, cons;
      flip        = (m_sync != m_stable_n) && (m_run == DEB - 1);
      press       = flip && m_stable_n;
      was_pressed = !m_stable_n;
      cons        = m_pend && ready;
      if (m_sync == m_stable_n) m_run = 0;
      else if (flip) begin m_run = 0; m_stable_n = m_sync; end
      else m_run++;
      m_sync = m_s1;
      m_s1   = button;
      if (m_pend) begin
        if (press && OVR_EN) m_ovr = 1'b1;
        else if (cons)       m_ovr = 1'b0;
        if (cons) begin
          m_pend = 1'b0;
          m_wait = was_pressed || press;
        end
      end else if (m_wait) begin
        if (!was_pressed) m_wait = 1'b0;
      end else if (press) begin
        m_pend = 1'b1;
        m_word = sw;
      end
    end
  end

  // Consume anything pending, release the button, and let the port return to idle.
  task automatic settle();
    button = 1'b1;
    ready  = 1'b1;
    repeat (12) @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({dv, dout, prs, ovr} !== 19'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {dv, dout, prs, ovr});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({dv, dout, prs, ovr} !== 19'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h required 0", {dv, dout, prs, ovr});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_clean_press();
    sw = 16'hA5C3; ready = 1'b0; button = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (dv !== (k >= 6) || prs !== (k >= 6)) begin
        n_fail++; $display("FAIL clean_press_valid edge %0d: got dv=%b pressed=%b required %b", k, dv, prs, k >= 6);
      end
      if (k >= 6) begin
        n_tests++;
        if (dout !== 16'hA5C3) begin
          n_fail++; $display("FAIL clean_press_data: got %h required a5c3", dout);
        end
      end
    end
    $display("[TB] test_clean_press done");
  endtask

  task automatic test_hold_consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_tests++;
    if (dv !== 1'b0) begin
      n_fail++; $display("FAIL hold_consume_drop: got dv=%b required 0", dv);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (dv !== 1'b0) begin
        n_fail++; $display("FAIL hold_no_second_word cycle %0d: got dv=%b required 0", k, dv);
      end
    end
    button = 1'b1;
    repeat (8) @(negedge clk);
    n_tests++;
    if (prs !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got pressed=%b required 0", prs);
    end
    sw = 16'h5A5A; button = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (dv !== 1'b1 || dout !== 16'h5A5A) begin
      n_fail++; $display("FAIL hold_new_word: got dv=%b data=%h required 1 5a5a", dv, dout);
    end
    settle();
    $display("[TB] test_hold_consume done");
  endtask

  task automatic test_bounce();
    sw = 16'h0F0F; button = 1'b0;
    repeat (3) @(negedge clk);
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_tests++;
      if (dv !== (k >= 6)) begin
        n_fail++; $display("FAIL bounce_valid edge %0d: got dv=%b required %b", k, dv, k >= 6);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (dv !== 1'b0 || dout !== 16'h0F0F) begin
      n_fail++; $display("FAIL bounce_single_word: got dv=%b data=%h required 0 0f0f", dv, dout);
    end
    settle();
    $display("[TB] test_bounce done");
  endtask

  task automatic test_overrun();
    sw = 16'h0001; button = 1'b0;
    repeat (7) @(negedge clk);
    button = 1'b1;
    repeat (8) @(negedge clk);
    sw = 16'h0002; button = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++;
    if (dv !== 1'b1 || dout !== 16'h0001 || ovr !== OVR_EN) begin
      n_fail++; $display("FAIL overrun_set: got dv=%b data=%h ovr=%b required 1 0001 %b", dv, dout, ovr, OVR_EN);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_tests++;
    if (dv !== 1'b0 || ovr !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: got dv=%b ovr=%b required 0 0", dv, ovr);
    end
    settle();
    $display("[TB] test_overrun done");
  endtask

  task automatic test_simultaneous();
    sw = 16'h0011; button = 1'b0;
    repeat (7) @(negedge clk);
    button = 1'b1;
    repeat (8) @(negedge clk);
    sw = 16'h0022; button = 1'b0;
    repeat (5) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_tests++;
    if (dv !== 1'b0 || ovr !== OVR_EN || prs !== 1'b1 || dout !== 16'h0011) begin
      n_fail++; $display("FAIL simul_consume: got dv=%b ovr=%b pressed=%b data=%h required 0 %b 1 0011",
                         dv, ovr, prs, dout, OVR_EN);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (dv !== 1'b0) begin
      n_fail++; $display("FAIL simul_no_extra_word: got dv=%b required 0", dv);
    end
    settle();
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_async_reset();
    sw = 16'hBEEF; button = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++;
    if (dv !== 1'b1 || dout !== 16'hBEEF) begin
      n_fail++; $display("FAIL areset_setup: got dv=%b data=%h required 1 beef", dv, dout);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dv, dout, prs, ovr} !== 19'd0) begin
      n_fail++; $display("FAIL areset_immediate: got %h required 0", {dv, dout, prs, ovr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_tests++;
      if (dv !== (k >= 6)) begin
        n_fail++; $display("FAIL areset_repress edge %0d: got dv=%b required %b", k, dv, k >= 6);
      end
    end
    settle();
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_random();
    int run_left = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_tests++;
      if (dv !== m_pend || prs !== !m_stable_n || ovr !== m_ovr || dout !== m_word) begin
        n_fail++;
        $display("FAIL random cycle %0d: got dv=%b pressed=%b ovr=%b data=%h required %b %b %b %h",
                 c, dv, prs, ovr, dout, m_pend, !m_stable_n, m_ovr, m_word);
      end
      if (run_left == 0) begin
        button   = $urandom_range(0, 1);
        run_left = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14));
      end
      run_left--;
      ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
    end
    settle();
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_hold_consume();
    test_bounce();
    test_overrun();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
